fifo_write_arbiter: RTL

// Shares the write port (shift_in/data_in/full) of one fifo instance between NUM_REQ requesters.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority search: first asserted request at or after rr_ptr, with modulo wrap.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   rr_ptr,
  output logic               found,
  output logic [TAG_W-1:0]   winner
);

  localparam int unsigned IW = TAG_W + 1;

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the closest hit to rr_ptr is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (req[idx[TAG_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[TAG_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one fifo write port between NUM_REQ requesters with round-robin grants
// and optional burst lock; grant, push and ack happen in the same cycle.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TAG_W     = tag_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       in_ready,
  input  logic                     fifo_full,
  output logic                     fifo_shift_in,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [TAG_W-1:0]         fifo_tag,
  output logic                     busy
);

  localparam int unsigned      CNT_W     = 8;
  localparam logic [TAG_W-1:0] LAST_IDX  = TAG_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(MAX_BURST);

  arb_state_e       state, state_nxt;
  logic [TAG_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [TAG_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic             found;
  logic [TAG_W-1:0] winner;
  logic [TAG_W-1:0] sel;
  logic             sel_ok;
  logic             xfer;
  logic [WIDTH-1:0] words [NUM_REQ];

  function automatic logic [TAG_W-1:0] next_idx(input logic [TAG_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + TAG_W'(1);
  endfunction

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_picker (
    .req    (in_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .winner (winner)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Grant and pass-through: a burst owner keeps the port, otherwise the picker decides.
  always_comb begin
    sel           = (state == BURST) ? owner : winner;
    sel_ok        = (state == BURST) || found;
    in_ready      = '0;
    if (!res && sel_ok && !fifo_full) in_ready = NUM_REQ'(1) << sel;
    xfer          = |(in_valid & in_ready);
    fifo_shift_in = xfer;
    fifo_data_in  = xfer ? words[sel] : '0;
    fifo_tag      = xfer ? sel : '0;
    busy          = (state == BURST);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // A full fifo with the owner still valid simply holds everything.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_nxt = next_idx(winner);
          end else begin
            state_nxt     = BURST;
            owner_nxt     = winner;
            burst_cnt_nxt = CNT_W'(1);
          end
        end
      end
      BURST: begin
        if (!in_valid[owner]) begin
          state_nxt     = IDLE;
          rr_ptr_nxt    = next_idx(owner);
          burst_cnt_nxt = '0;
        end else if (xfer) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
          if (burst_cnt_nxt == BURST_LEN) begin
            state_nxt     = IDLE;
            rr_ptr_nxt    = next_idx(owner);
            burst_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
